// File: rtl/clk_meter_if.sv
// clk_meter_if: control and result bundle between clk_meter and its user
//   start               master -> slave  one-cycle measurement request
//   busy/done/timeout   slave -> master  handshake and status
//   period_sum/high_sum slave -> master  SUM_W-bit window sums (clk cycles)
//   period_min/max      slave -> master  CNT_W-bit single-period extremes
interface clk_meter_if #(
    parameter int CNT_W       = 16,
    parameter int NUM_PERIODS = 8
);
    localparam int SUM_W = CNT_W + $clog2(NUM_PERIODS) + 1;
    logic             start;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [SUM_W-1:0] period_sum;
    logic [SUM_W-1:0] high_sum;
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;
    modport master (output start, input busy, done, timeout, period_sum, high_sum, period_min, period_max);
    modport slave  (input start, output busy, done, timeout, period_sum, high_sum, period_min, period_max);
endinterface

// File: rtl/clk_meter.sv
// clk_meter: measures period sum, high-time sum and min/max period of an async clock
//   clk       system clock, all logic on its rising edge
//   rst_n     asynchronous active-low reset
//   meas_clk  clock under test, asynchronous to clk
//   bus       clk_meter_if.slave: start in; busy/done/timeout/results out
// Define CLK_METER_JITTER_EN to build min/max period tracking; otherwise
// period_min/period_max are tied to 0.
module clk_meter #(
    parameter int CNT_W       = 16,
    parameter int NUM_PERIODS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        meas_clk,
    clk_meter_if.slave  bus
);
    localparam int SUM_W  = CNT_W + $clog2(NUM_PERIODS) + 1;
    localparam int EDGE_W = $clog2(NUM_PERIODS + 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [SUM_W-1:0]  period_sum_q, period_sum_d;
    logic [SUM_W-1:0]  high_sum_q, high_sum_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              rise, busy, accept, meas_rise, close, tmo;

    assign rise      = s2_q & ~s3_q;
    assign accept    = state_q == IDLE && bus.start && !done_q;
    assign meas_rise = state_q == MEASURE && rise;
    assign close     = meas_rise && edge_cnt_q == EDGE_W'(NUM_PERIODS - 1);
    // Timeout fires on the cycle the counter would saturate, so done lands
    // exactly 2^CNT_W-1 cycles after ARM entry with no rise seen.
    assign tmo       = busy && !rise && &per_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ARM : IDLE;
            ARM:     state_d = rise ? MEASURE : (tmo ? IDLE : ARM);
            MEASURE: state_d = (close || tmo) ? IDLE : MEASURE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
    end

    always_comb begin
        per_cnt_d    = accept ? '0 : (busy ? (rise ? CNT_W'(1) : per_cnt_q + CNT_W'(1)) : per_cnt_q);
        edge_cnt_d   = accept ? '0 : (meas_rise ? edge_cnt_q + EDGE_W'(1) : edge_cnt_q);
        period_sum_d = accept ? '0 : (meas_rise ? period_sum_q + SUM_W'(per_cnt_q) : period_sum_q);
        // Window is [first rise, closing rise): ARM counts only its rise cycle.
        high_sum_d   = accept ? '0 :
                       ((state_q == MEASURE || rise) && busy && s2_q && !close) ? high_sum_q + SUM_W'(1) : high_sum_q;
        done_d       = close || tmo;
        timeout_d    = accept ? 1'b0 : (tmo ? 1'b1 : timeout_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            per_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            period_sum_q <= '0;
            high_sum_q   <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            s1_q         <= meas_clk;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            per_cnt_q    <= per_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            period_sum_q <= period_sum_d;
            high_sum_q   <= high_sum_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef CLK_METER_JITTER_EN
    logic [CNT_W-1:0] period_min_q, period_min_d;
    logic [CNT_W-1:0] period_max_q, period_max_d;

    always_comb begin
        period_min_d = accept ? '1 : ((meas_rise && per_cnt_q < period_min_q) ? per_cnt_q : period_min_q);
        period_max_d = accept ? '0 : ((meas_rise && per_cnt_q > period_max_q) ? per_cnt_q : period_max_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_min_q <= '0;
            period_max_q <= '0;
        end else begin
            period_min_q <= period_min_d;
            period_max_q <= period_max_d;
        end
    end

    assign bus.period_min = period_min_q;
    assign bus.period_max = period_max_q;
`else
    assign bus.period_min = '0;
    assign bus.period_max = '0;
`endif

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.period_sum = period_sum_q;
    assign bus.high_sum   = high_sum_q;
endmodule

// File: tb/tb_clk_meter.sv
// tb_clk_meter: directed self-checking bench for clk_meter (CNT_W=8, NUM_PERIODS=8)
module tb_clk_meter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic meas_clk = 1'b0;
  logic run = 1'b0;
  logic ph = 1'b0;
  int hi = 5, lo_a = 5, lo_b = 5;
  int checks = 0, errors = 0;
  int n;
  clk_meter_if #(.CNT_W(8), .NUM_PERIODS(8)) bus ();
  clk_meter #(.CNT_W(8), .NUM_PERIODS(8)) dut (.clk(clk), .rst_n(rst_n), .meas_clk(meas_clk), .bus(bus));
  always #5 clk = ~clk;
`ifdef CLK_METER_JITTER_EN
  localparam bit JIT = 1'b1;
`else
  localparam bit JIT = 1'b0;
`endif
  initial begin
    forever begin
      if (!run) @(negedge clk);
      else begin
        meas_clk = 1'b1;
        repeat (hi) @(negedge clk);
        meas_clk = 1'b0;
        repeat (ph ? lo_b : lo_a) @(negedge clk);
        ph = ~ph;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask
  task automatic do_start;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask
  task automatic pattern(input int h, input int a, input int b);
    run = 1'b0;
    step(50);
    hi = h; lo_a = a; lo_b = b; ph = 1'b0;
    run = 1'b1;
    step(30);
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin step(1); cyc++; end
    chk("done_seen", bus.done, 1'b1);
  endtask
  task automatic check_result(input int ps, input int hs, input int mn, input int mx);
    chk("period_sum", bus.period_sum, ps);
    chk("high_sum", bus.high_sum, hs);
    chk("period_min", bus.period_min, JIT ? mn : 0);
    chk("period_max", bus.period_max, JIT ? mx : 0);
    chk("timeout_clear", bus.timeout, 1'b0);
    chk("busy_at_done", bus.busy, 1'b0);
  endtask
  initial begin
    bus.start = 1'b0;
    #23;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_period_sum", bus.period_sum, 0);
    chk("rst_high_sum", bus.high_sum, 0);
    chk("rst_min", bus.period_min, 0);
    chk("rst_max", bus.period_max, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    pattern(5, 5, 5);
    do_start;
    chk("busy_after_start", bus.busy, 1'b1);
    wait_done(n);
    check_result(80, 40, 10, 10);
    step(1);
    chk("done_one_cycle", bus.done, 1'b0);
    pattern(5, 15, 15);
    do_start;
    wait_done(n);
    check_result(160, 40, 20, 20);
    pattern(4, 5, 7);
    do_start;
    wait_done(n);
    check_result(80, 32, 9, 11);
    run = 1'b0;
    step(50);
    do_start;
    chk("tmo_busy", bus.busy, 1'b1);
    wait_done(n);
    chk("tmo_latency", n, 255);
    chk("tmo_flag", bus.timeout, 1'b1);
    chk("tmo_busy_low", bus.busy, 1'b0);
    do_start;
    chk("start_on_done_ignored", bus.busy, 1'b0);
    chk("tmo_held", bus.timeout, 1'b1);
    pattern(5, 5, 5);
    do_start;
    chk("restart_clears_timeout", bus.timeout, 1'b0);
    step(40);
    do_start;
    chk("busy_through_extra_start", bus.busy, 1'b1);
    wait_done(n);
    check_result(80, 40, 10, 10);
    n = 0;
    repeat (100) begin step(1); if (bus.done === 1'b1) n++; end
    chk("single_done", n, 0);
    do_start;
    step(40);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_period_sum", bus.period_sum, 0);
    chk("arst_high_sum", bus.high_sum, 0);
    chk("arst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (60) begin step(1); if (bus.done === 1'b1) n++; end
    chk("no_done_after_reset", n, 0);
    do_start;
    wait_done(n);
    check_result(80, 40, 10, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_meter.md
# clk_meter

Synthesizable clock measurement block: samples an asynchronous clock under test (`meas_clk`) in the system `clk` domain and measures it over a window of `NUM_PERIODS` rising edges. It reports period sum, high-time sum, and min/max single period, all in `clk` cycles. It is the on-chip counterpart to the user-defined frequency/duty/jitter clock generator, and checks generated clocks in hardware rather than with simulation-time `$realtime` arithmetic. Software derives frequency (`NUM_PERIODS*f_clk/period_sum`), duty (`high_sum/period_sum`) and jitter (`period_max-period_min`).

## Interface
- `CNT_W`, 16, width of per-period counter and of `period_min`/`period_max`.
- `NUM_PERIODS`, 8, number of `meas_clk` periods per window; ≥1.
- `SUM_W`, `CNT_W+$clog2(NUM_PERIODS)+1`, width of `period_sum`/`high_sum` (derived, do not override).

Ports:
- `clk`  in  1  system reference clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `meas_clk`  in  1  clock under test, asynchronous to `clk`.
- `start`  in  1  one-cycle request to begin a measurement; sampled only in IDLE.
- `busy`  out  1  high in ARM and MEASURE.
- `done`  out  1  one-cycle pulse when a window completes or times out.
- `timeout`  out  1  set with `done` when no edge arrives in time; held until next accepted `start`.
- `period_sum`  out  SUM_W  `clk` cycles spanning `NUM_PERIODS` periods.
- `high_sum`  out  SUM_W  `clk` cycles in which synchronized `meas_clk` was high within the window.
- `period_min`  out  CNT_W  shortest single period in the window.
- `period_max`  out  CNT_W  longest single period in the window.

## Operation
- Synchronizer: `s1 <= meas_clk; s2 <= s1; s3 <= s2`. `rise = s2 & ~s3`. Each `meas_clk` level must last ≥2 `clk` cycles; shorter pulses are not guaranteed to be detected.
- FSM states: IDLE, ARM, MEASURE. No separate DONE state; `done` is a registered pulse.
- IDLE + `start`: go to ARM. Clear `timeout`, sums, `per_cnt` and `edge_cnt`. Set `period_min` to all-ones and `period_max` to 0.
- ARM: `per_cnt` increments each cycle.
  - On `rise`: load `per_cnt := 1` and go to MEASURE.
  - The `rise` cycle itself counts toward `high_sum` (`s2`=1).
- MEASURE, cycle without `rise`: `per_cnt++`. If `s2`=1, `high_sum++`.
- MEASURE, `rise` cycle:
  - Add `per_cnt` to `period_sum` and update min/max with `per_cnt`.
  - Load `per_cnt := 1` and increment `edge_cnt`.
  - If `edge_cnt` reaches `NUM_PERIODS`: pulse `done` next cycle and go to IDLE. The closing `rise` cycle does not count toward `high_sum`.
  - Otherwise the `rise` cycle counts toward `high_sum`.
- Window: `high_sum` covers cycles [first rise, closing rise).
- Timeout: if `per_cnt` equals `2^CNT_W-1` in ARM or MEASURE:
  - Go to IDLE, pulse `done`, set `timeout`=1.
  - Outputs hold partial values and are invalid.
- `start` while `busy` is ignored. `start` on the same cycle as `done` is ignored; it is accepted from the following cycle.
- Result outputs are stable from `done` until the next accepted `start`.
- Sums cannot overflow given `SUM_W`.

## Timing
- Reset values: `busy`=0, `done`=0, `timeout`=0, `period_sum`=0, `high_sum`=0, `period_min`=0, `period_max`=0; FSM in IDLE; synchronizer flops 0.
- Asynchronous reset mid-measurement aborts immediately. No `done` is issued.
- `busy` rises the cycle after `start` is accepted.
- The first rise is detected 2–3 `clk` cycles after the `meas_clk` edge (synchronizer latency).
- `done` asserts exactly 1 cycle after the `rise` that closes period `NUM_PERIODS`. The results are valid in that same cycle. `busy` falls in that cycle.
- Worst-case latency from `start` to `done`: ≈ (`NUM_PERIODS`+1)·T_meas + 4 cycles. With timeout: ≤ (`NUM_PERIODS`+1)·(2^CNT_W−1) + 2 cycles.

## Configuration
- `CLK_METER_JITTER_EN` defined: min/max tracking compiled in as described above.
- `CLK_METER_JITTER_EN` undefined: min/max compare logic and registers are removed. `period_min` and `period_max` are tied to 0. Sums, timeout and handshake are unchanged.

## Test plan
- 50% duty, `meas_clk` period 10 `clk` cycles, defaults → `period_sum`=80, `high_sum`=40, `period_min`=`period_max`=10, one `done`, `timeout`=0.
- 25% duty, period 20 → `period_sum`=160, `high_sum`=40, min=max=20.
- Periods alternating 9/11, high=4 → `period_sum`=80, `high_sum`=32, min=9, max=11. With `CLK_METER_JITTER_EN` undefined: min=max=0, sums identical.
- `meas_clk` stuck low, `CNT_W`=8 → `done`+`timeout`=1 exactly 255 cycles after ARM entry; `busy`=0 after.
- `start` pulsed again during MEASURE → ignored, single `done`. Next `start` after `done` clears `timeout` and re-measures correctly.
- `rst_n` low mid-MEASURE → all outputs 0 asynchronously, no `done`. A fresh `start` after release gives correct results.
